ide_pio_sequencer: RTL

Clocked PIO cycle sequencer for the IDE port on the 68000 bus. It replaces fixed AS-delay strobe timing with a state machine that enforces programmable setup, active and recovery times, and honours drive IORDY with a bounded wait. It raises DTACK only once the drive transfer is complete. It sits between the address decode (which supplies `ide_select`) and the IDE connector strobes.

---
 rtl/ide_pio_sequencer_if.sv | 28 ++
 rtl/ide_pio_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/ide_pio_sequencer_if.sv
// 68000-side bus and IDE strobe signals of the PIO sequencer.
// Handshake: a cycle is requested while AS_n is low with a data strobe and
// ide_select; DTACK answers once the drive transfer completes and drops on
// the first edge that samples AS_n high.
interface ide_pio_sequencer_if;
    logic       AS_n;
    logic       UDS_n;
    logic       LDS_n;
    logic       RW;
    logic       ide_select;
    logic       IORDY;
    logic       IOR_n;
    logic       IOW_n;
    logic       DTACK;
    logic       BUSY;
    logic       timeout_err;
    logic [2:0] state_dbg;

    modport master (
        output AS_n, UDS_n, LDS_n, RW, ide_select, IORDY,
        input  IOR_n, IOW_n, DTACK, BUSY, timeout_err, state_dbg
    );

    modport slave (
        input  AS_n, UDS_n, LDS_n, RW, ide_select, IORDY,
        output IOR_n, IOW_n, DTACK, BUSY, timeout_err, state_dbg
    );
endinterface

// File: rtl/ide_pio_sequencer.sv
// IDE PIO cycle sequencer: programmable setup/active/recovery timing with a
// bounded IORDY wait, acknowledging the 68000 only after the drive transfer.
module ide_pio_sequencer #(
    parameter int SETUP_CYCLES    = 1,
    parameter int ACTIVE_CYCLES   = 3,
    parameter int RECOVERY_CYCLES = 2,
    parameter int IORDY_TIMEOUT   = 64
) (
    input  logic               CLK,
    input  logic               RESET,
    ide_pio_sequencer_if.slave bus
);
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] ACT_LD   = 8'(ACTIVE_CYCLES - 1);
    localparam logic [7:0] REC_LD   = 8'(RECOVERY_CYCLES - 1);
    localparam logic [7:0] TO_LAST  = 8'(IORDY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_ACTIVE, S_WAIT_RDY, S_DONE, S_RECOVER
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] wcnt;
    logic       rd_q;
    logic       iordy_m;
    logic       iordy_s;
    logic       req;

    assign req           = !bus.AS_n && (!bus.UDS_n || !bus.LDS_n) && bus.ide_select;
    assign bus.BUSY      = (state != S_IDLE);
    assign bus.state_dbg = state;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            iordy_m <= 1'b0;
            iordy_s <= 1'b0;
        end else begin
            iordy_m <= bus.IORDY;
            iordy_s <= iordy_m;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state           <= S_IDLE;
            cnt             <= 8'd0;
            wcnt            <= 8'd0;
            rd_q            <= 1'b0;
            bus.IOR_n       <= 1'b1;
            bus.IOW_n       <= 1'b1;
            bus.DTACK       <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        state           <= S_SETUP;
                        cnt             <= SETUP_LD;
                        rd_q            <= bus.RW;
                        bus.timeout_err <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (bus.AS_n) begin
                        state <= S_RECOVER;
                        cnt   <= REC_LD;
                    end else if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state     <= S_ACTIVE;
                        cnt       <= ACT_LD;
                        bus.IOR_n <= !rd_q;
                        bus.IOW_n <= rd_q;
                    end
                end
                S_ACTIVE: begin
                    if (bus.AS_n) begin
                        state     <= S_RECOVER;
                        cnt       <= REC_LD;
                        bus.IOR_n <= 1'b1;
                        bus.IOW_n <= 1'b1;
                    end else if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else if (iordy_s) begin
                        state     <= S_DONE;
                        bus.DTACK <= 1'b1;
                        bus.IOW_n <= 1'b1;
                    end else begin
                        state <= S_WAIT_RDY;
                        wcnt  <= 8'd0;
                    end
                end
                S_WAIT_RDY: begin
                    // Ready is checked before the timeout so a late IORDY still wins.
                    if (bus.AS_n) begin
                        state     <= S_RECOVER;
                        cnt       <= REC_LD;
                        bus.IOR_n <= 1'b1;
                        bus.IOW_n <= 1'b1;
                    end else if (iordy_s) begin
                        state     <= S_DONE;
                        bus.DTACK <= 1'b1;
                        bus.IOW_n <= 1'b1;
                    end else if (wcnt == TO_LAST) begin
                        state           <= S_DONE;
                        bus.DTACK       <= 1'b1;
                        bus.IOW_n       <= 1'b1;
                        bus.timeout_err <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                S_DONE: begin
                    // A read keeps IOR_n low until the CPU ends its bus cycle.
                    if (bus.AS_n) begin
                        state     <= S_RECOVER;
                        cnt       <= REC_LD;
                        bus.IOR_n <= 1'b1;
                        bus.IOW_n <= 1'b1;
                        bus.DTACK <= 1'b0;
                    end
                end
                S_RECOVER: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
